player_input_ctrl: RTL and testbench

Front-end controller that turns raw board push-buttons into the player column and missile-enable bus consumed by the VGA sprite pipeline. It synchronizes and debounces three buttons, steps the player column once per video frame with clamping, and allocates eight missile slots whose enable bits stay high for a fixed number of frames. It sits in the VGA clock domain between the GPIO pins and the `btn_col` / `btn_missle_en` inputs of the VGA top level.

---
 rtl/player_input_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_player_input_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// player_input_ctrl
//
// Front end between the board push-buttons and the VGA sprite pipeline.
// Synchronizes and debounces the left/right/fire buttons, steps the player
// column once per video frame with clamping, and manages eight missile slots
// whose enable bits stay high for MISSILE_FRAMES frames after a fire event.
//
// Ports
//   vga_clk_i      in   VGA pixel clock (only clock)
//   vga_rst_i      in   asynchronous reset, active low
//   btn_left       in   raw left button, asynchronous, active high
//   btn_right      in   raw right button, asynchronous, active high
//   btn_fire       in   raw fire button, asynchronous, active high
//   vga_vs         in   vertical sync, active-low pulse
//   btn_col        out  player column in pixels (registered)
//   btn_missle_en  out  bit k high while missile slot k is in flight
//   missiles_full  out  high when all 8 slots are in flight (registered)
//
// Build option
//   PLAYER_AUTOFIRE_EN  when defined, a held fire button re-fires every
//                       AUTOFIRE_FRAMES frame ticks after its rising edge.
// -----------------------------------------------------------------------------
module player_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COL_MIN         = 0,
  parameter int COL_MAX         = 608,
  parameter int COL_INIT        = 304,
  parameter int STEP            = 4,
  parameter int MISSILE_FRAMES  = 60,
  parameter int AUTOFIRE_FRAMES = 15
) (
  input  logic        vga_clk_i,
  input  logic        vga_rst_i,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        vga_vs,
  output logic [11:0] btn_col,
  output logic [7:0]  btn_missle_en,
  output logic        missiles_full
);

  localparam int                 DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic signed [12:0] C_STEP = 13'(STEP);
  localparam logic signed [12:0] C_MIN  = 13'(COL_MIN);
  localparam logic signed [12:0] C_MAX  = 13'(COL_MAX);
  localparam logic [5:0]         C_MF   = 6'(MISSILE_FRAMES);

  // Out-of-range frame counts would silently wrap the 6-bit / 5-bit counters.
  if (MISSILE_FRAMES < 1 || MISSILE_FRAMES > 63 ||
      AUTOFIRE_FRAMES < 1 || AUTOFIRE_FRAMES > 31) begin : g_bad_param
    $error("player_input_ctrl: MISSILE_FRAMES must be 1..63, AUTOFIRE_FRAMES 1..31");
  end

  // Button index: 0 = left, 1 = right, 2 = fire.
  logic [2:0]      w_btn_raw;
  logic [2:0]      r_btn_s0;
  logic [2:0]      r_btn_s1;
  logic [2:0]      r_btn_db;
  logic [DB_W-1:0] r_db_cnt [3];

  logic r_vs_s0;
  logic r_vs_s1;
  logic r_vs_d;
  logic w_frame_tick;

  logic r_fire_d;
  logic w_fire_rise;
  logic w_fire_evt;

  logic signed [12:0] w_col_s;
  logic signed [12:0] w_col_left;
  logic signed [12:0] w_col_right;
  logic [11:0]        w_col_next;

  logic [7:0] w_free;
  logic [7:0] w_alloc;
  logic [7:0] w_en_next;
  logic [5:0] w_cnt_next [8];
  logic [5:0] r_slot_cnt [8];

  assign w_btn_raw = {btn_fire, btn_right, btn_left};

  // ---- Button synchronizers and debounce ------------------------------------
  // A counter only runs while the synchronized level disagrees with the
  // debounced one; any agreement (a glitch ending) restarts it from zero.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_btn_s0 <= '0;
      r_btn_s1 <= '0;
      r_btn_db <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_btn_s0 <= w_btn_raw;
      r_btn_s1 <= r_btn_s0;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_s1[i] == r_btn_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_MAX) begin
          r_btn_db[i] <= ~r_btn_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---- Frame tick and fire edge ----------------------------------------------
  // Sync chain resets low so a vsync already high at reset release is seen as
  // a rising edge and never produces a spurious tick.
  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_vs_s0  <= 1'b0;
      r_vs_s1  <= 1'b0;
      r_vs_d   <= 1'b0;
      r_fire_d <= 1'b0;
    end else begin
      r_vs_s0  <= vga_vs;
      r_vs_s1  <= r_vs_s0;
      r_vs_d   <= r_vs_s1;
      r_fire_d <= r_btn_db[2];
    end
  end

  assign w_frame_tick = r_vs_d & ~r_vs_s1;
  assign w_fire_rise  = r_btn_db[2] & ~r_fire_d;

`ifdef PLAYER_AUTOFIRE_EN
  localparam logic [4:0] AF_LAST = 5'(AUTOFIRE_FRAMES - 1);

  logic [4:0] r_af_cnt;
  logic       w_af_evt;

  // A tick in the same cycle as the rising edge does not count toward the
  // first repeat; the period starts after the edge.
  assign w_af_evt = r_btn_db[2] & ~w_fire_rise & w_frame_tick &
                    (r_af_cnt == AF_LAST);

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      r_af_cnt <= '0;
    end else if (w_fire_rise) begin
      r_af_cnt <= '0;
    end else if (r_btn_db[2] && w_frame_tick) begin
      r_af_cnt <= (r_af_cnt == AF_LAST) ? 5'd0 : r_af_cnt + 5'd1;
    end
  end

  assign w_fire_evt = w_fire_rise | w_af_evt;
`else
  assign w_fire_evt = w_fire_rise;
`endif

  // ---- Player column ---------------------------------------------------------
  // Signed 13-bit math so stepping left from a small column goes negative
  // and clamps instead of wrapping to a large unsigned value.
  assign w_col_s     = signed'({1'b0, btn_col});
  assign w_col_left  = w_col_s - C_STEP;
  assign w_col_right = w_col_s + C_STEP;

  always_comb begin
    w_col_next = btn_col;
    if (r_btn_db[0] && !r_btn_db[1]) begin
      w_col_next = (w_col_left < C_MIN) ? C_MIN[11:0] : w_col_left[11:0];
    end else if (r_btn_db[1] && !r_btn_db[0]) begin
      w_col_next = (w_col_right > C_MAX) ? C_MAX[11:0] : w_col_right[11:0];
    end
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      btn_col <= 12'(COL_INIT);
    end else if (w_frame_tick) begin
      btn_col <= w_col_next;
    end
  end

  // ---- Missile slots -----------------------------------------------------------
  // Allocation looks at the current (pre-expiry) enables, so a slot expiring
  // this cycle is not reusable until the next one. x & -x isolates the
  // lowest free slot.
  assign w_free  = ~btn_missle_en;
  assign w_alloc = w_fire_evt ? (w_free & (~w_free + 8'd1)) : 8'd0;

  always_comb begin
    w_en_next = btn_missle_en;
    for (int k = 0; k < 8; k++) begin
      w_cnt_next[k] = r_slot_cnt[k];
      if (w_alloc[k]) begin
        w_en_next[k]  = 1'b1;
        w_cnt_next[k] = C_MF;
      end else if (btn_missle_en[k] && w_frame_tick) begin
        w_cnt_next[k] = r_slot_cnt[k] - 6'd1;
        if (r_slot_cnt[k] == 6'd1) w_en_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
    if (!vga_rst_i) begin
      btn_missle_en <= '0;
      missiles_full <= 1'b0;
      for (int k = 0; k < 8; k++) r_slot_cnt[k] <= '0;
    end else begin
      btn_missle_en <= w_en_next;
      missiles_full <= &w_en_next;
      for (int k = 0; k < 8; k++) r_slot_cnt[k] <= w_cnt_next[k];
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
`timescale 1ns/1ps
module tb_player_input_ctrl;

  localparam int D     = 200;
  localparam int MF    = 60;
  localparam int AF    = 15;
  localparam int CMIN  = 0;
  localparam int CMAX  = 608;
  localparam int CINIT = 304;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bl = 1'b0;
  logic        br = 1'b0;
  logic        bf = 1'b0;
  logic        vs = 1'b1;
  logic [11:0] col;
  logic [7:0]  en;
  logic        full;

  always #5 clk = ~clk;

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .COL_MIN(CMIN),
    .COL_MAX(CMAX),
    .COL_INIT(CINIT),
    .STEP(STEP),
    .MISSILE_FRAMES(MF),
    .AUTOFIRE_FRAMES(AF)
  ) dut (
    .vga_clk_i(clk),
    .vga_rst_i(rst_n),
    .btn_left(bl),
    .btn_right(br),
    .btn_fire(bf),
    .vga_vs(vs),
    .btn_col(col),
    .btn_missle_en(en),
    .missiles_full(full)
  );

  typedef struct packed {
    logic [11:0] col;
    logic [7:0]  en;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Transaction-level reference model of the visible state.
  int       m_col = CINIT;
  bit [7:0] m_en  = '0;
  int       m_cnt [8];
  bit       m_l   = 1'b0;
  bit       m_r   = 1'b0;
`ifdef PLAYER_AUTOFIRE_EN
  bit       m_f   = 1'b0;
  int       m_af  = 0;
`endif

  function automatic void model_step(bit frame, bit fire);
    bit [7:0] pre;
    bit       fire_e;
    bit       done;
    pre    = m_en;
    fire_e = fire;
    if (frame) begin
      if (m_l && !m_r)      m_col = (m_col - STEP < CMIN) ? CMIN : m_col - STEP;
      else if (m_r && !m_l) m_col = (m_col + STEP > CMAX) ? CMAX : m_col + STEP;
`ifdef PLAYER_AUTOFIRE_EN
      if (m_f && !fire) begin
        m_af++;
        if (m_af == AF) begin
          m_af   = 0;
          fire_e = 1'b1;
        end
      end
`endif
      for (int k = 0; k < 8; k++) begin
        if (pre[k]) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_en[k] = 1'b0;
        end
      end
    end
`ifdef PLAYER_AUTOFIRE_EN
    if (fire) m_af = 0;
`endif
    done = 1'b0;
    if (fire_e) begin
      for (int k = 0; k < 8; k++) begin
        if (!done && !pre[k]) begin
          m_en[k]  = 1'b1;
          m_cnt[k] = MF;
          done     = 1'b1;
        end
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.col  = m_col[11:0];
    e.en   = m_en;
    e.full = &m_en;
    sb.push_back(e);
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // One vsync pulse; the column update lands 3 clocks after the falling edge.
  task automatic do_frame();
    @(negedge clk);
    vs = 1'b0;
    model_step(1'b1, 1'b0);
    push_exp();
    cyc(4);
    vs = 1'b1;
    cyc(4);
  endtask

  task automatic set_dirs(bit l, bit r);
    @(negedge clk);
    bl = l;
    br = r;
    cyc(D + 6);
    m_l = l;
    m_r = r;
  endtask

  task automatic fire_press();
    @(negedge clk);
    bf = 1'b1;
    cyc(D + 6);
    model_step(1'b0, 1'b1);
    push_exp();
    bf = 1'b0;
    cyc(D + 6);
  endtask

  // Debounced fire rises in the very cycle frame_tick is high.
  task automatic fire_with_frame();
    @(negedge clk);
    bf = 1'b1;
    cyc(D + 1);
    vs = 1'b0;
    model_step(1'b1, 1'b1);
    push_exp();
    cyc(4);
    vs = 1'b1;
    bf = 1'b0;
    cyc(D + 6);
  endtask

  task automatic test_reset();
    exp_t e;
    cyc(3);
    n_chk++;
    if (col !== 12'(CINIT) || en !== 8'h00 || full !== 1'b0)
      $display("FAIL reset_held: col=%0d en=%h full=%b required col=%0d en=00 full=0", col, en, full, CINIT);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    cyc(5);
    e = sb.pop_front();
    n_chk++;
    if (col !== e.col || en !== e.en || full !== e.full)
      $display("FAIL reset_release: col=%0d en=%h full=%b required col=%0d en=%h full=%b", col, en, full, e.col, e.en, e.full);
    else n_pass++;
  endtask

  task automatic test_move_right();
    exp_t e;
    set_dirs(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (col !== e.col || en !== e.en || full !== e.full)
        $display("FAIL move_right f%0d: col=%0d en=%h full=%b required col=%0d en=%h full=%b", i, col, en, full, e.col, e.en, e.full);
      else n_pass++;
    end
    n_chk++;
    if (col !== 12'd344) $display("FAIL move_right_final: col=%0d required 344", col);
    else n_pass++;
  endtask

  task automatic test_clamp();
    exp_t e;
    set_dirs(1'b1, 1'b0);
    for (int i = 0; i < 90; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (col !== e.col || en !== e.en)
        $display("FAIL clamp_left f%0d: col=%0d en=%h required col=%0d en=%h", i, col, en, e.col, e.en);
      else n_pass++;
    end
    n_chk++;
    if (col !== 12'd0) $display("FAIL clamp_left_final: col=%0d required 0", col);
    else n_pass++;
    set_dirs(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (col !== e.col || col !== 12'd0)
        $display("FAIL both_held f%0d: col=%0d required %0d", i, col, e.col);
      else n_pass++;
    end
    set_dirs(1'b0, 1'b1);
    for (int i = 0; i < 155; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (col !== e.col)
        $display("FAIL clamp_right f%0d: col=%0d required %0d", i, col, e.col);
      else n_pass++;
    end
    n_chk++;
    if (col !== 12'(CMAX)) $display("FAIL clamp_right_final: col=%0d required %0d", col, CMAX);
    else n_pass++;
    set_dirs(1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bf = 1'b1;
      cyc(100);
      bf = 1'b0;
      cyc(100);
    end
    cyc(D + 6);
    n_chk++;
    if (en !== 8'h00 || full !== 1'b0)
      $display("FAIL glitch: en=%h full=%b required en=00 full=0", en, full);
    else n_pass++;
  endtask

  task automatic test_single_flight();
    exp_t e;
    @(negedge clk);
    bf = 1'b1;
    cyc(D + 3);
    n_chk++;
    if (en !== 8'h00) $display("FAIL fire_latency_early: en=%h required 00", en);
    else n_pass++;
    cyc(1);
    model_step(1'b0, 1'b1);
    push_exp();
    e = sb.pop_front();
    n_chk++;
    if (en !== e.en || en !== 8'h01)
      $display("FAIL fire_latency: en=%h required %h", en, e.en);
    else n_pass++;
    bf = 1'b0;
    cyc(D + 6);
    for (int i = 1; i <= MF; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (en !== e.en || en[0] !== (i < MF))
        $display("FAIL flight_len f%0d: en=%h required %h", i, en, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    exp_t e;
    logic [7:0] pat;
    for (int i = 0; i < 9; i++) begin
      fire_press();
      e = sb.pop_front();
      pat = (i >= 7) ? 8'hFF : 8'((1 << (i + 1)) - 1);
      n_chk++;
      if (en !== e.en || en !== pat || full !== (i >= 7))
        $display("FAIL fill p%0d: en=%h full=%b required en=%h full=%b", i, en, full, pat, (i >= 7));
      else n_pass++;
    end
  endtask

  task automatic test_expiry_collision();
    exp_t e;
    for (int i = 0; i < MF - 1; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (en !== e.en || full !== e.full)
        $display("FAIL full_wait f%0d: en=%h full=%b required en=%h full=%b", i, en, full, e.en, e.full);
      else n_pass++;
    end
    fire_with_frame();
    e = sb.pop_front();
    n_chk++;
    if (en !== e.en || en !== 8'h00 || full !== 1'b0)
      $display("FAIL expiry_collision: en=%h full=%b required en=00 full=0", en, full);
    else n_pass++;
    // Same coincidence with slots free: the new slot is not decremented.
    fire_with_frame();
    e = sb.pop_front();
    n_chk++;
    if (en !== e.en || en !== 8'h01)
      $display("FAIL fire_on_tick: en=%h required 01", en);
    else n_pass++;
    for (int i = 1; i <= MF; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (en !== e.en)
        $display("FAIL fire_on_tick_flight f%0d: en=%h required %h", i, en, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    set_dirs(1'b1, 1'b0);
    for (int i = 0; i < 27; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (col !== e.col)
        $display("FAIL to_500 f%0d: col=%0d required %0d", i, col, e.col);
      else n_pass++;
    end
    set_dirs(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      fire_press();
      e = sb.pop_front();
      n_chk++;
      if (en !== e.en)
        $display("FAIL five_slots p%0d: en=%h required %h", i, en, e.en);
      else n_pass++;
    end
    n_chk++;
    if (col !== 12'd500 || en !== 8'h1F)
      $display("FAIL pre_reset: col=%0d en=%h required col=500 en=1f", col, en);
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (col !== 12'(CINIT) || en !== 8'h00 || full !== 1'b0)
      $display("FAIL async_reset: col=%0d en=%h full=%b required col=%0d en=00 full=0", col, en, full, CINIT);
    else n_pass++;
    m_col = CINIT;
    m_en  = '0;
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

`ifdef PLAYER_AUTOFIRE_EN
  task automatic test_autofire();
    exp_t e;
    @(negedge clk);
    bf = 1'b1;
    cyc(D + 6);
    model_step(1'b0, 1'b1);
    m_f = 1'b1;
    push_exp();
    e = sb.pop_front();
    n_chk++;
    if (en !== e.en) $display("FAIL autofire_edge: en=%h required %h", en, e.en);
    else n_pass++;
    for (int i = 0; i < 46; i++) begin
      do_frame();
      e = sb.pop_front();
      n_chk++;
      if (en !== e.en)
        $display("FAIL autofire f%0d: en=%h required %h", i, en, e.en);
      else n_pass++;
    end
    n_chk++;
    if (en !== 8'h0F) $display("FAIL autofire_count: en=%h required 0f", en);
    else n_pass++;
    bf  = 1'b0;
    m_f = 1'b0;
    cyc(D + 6);
  endtask
`endif

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    test_reset();
    test_move_right();
    test_clamp();
    test_glitch();
    test_single_flight();
    test_fill();
    test_expiry_collision();
    test_reset_midflight();
`ifdef PLAYER_AUTOFIRE_EN
    test_autofire();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
